mult_seq: RTL and testbench

Sequential unsigned shift-and-add multiplier, the multiply counterpart to the team's restoring-divider datapath in the same arithmetic-unit family. It accepts two N-bit operands on a start pulse and runs N add/shift iterations over an (N+1)-bit accumulator A and an N-bit register Q. It then presents a 2N-bit product with a one-cycle done strobe. Control FSM and datapath are in one block, driven by a simple start/busy/done handshake.

---
 rtl/arith_pkg.sv | 19 +
 rtl/acc_aq_shr.sv | 57 +++++
 rtl/mult_seq.sv | 107 ++++++++++
 tb/tb_mult_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arith_pkg
//  Description : Shared types and constants for the arithmetic-unit family.
//  Revision    : 1.0
// ============================================================================
package arith_pkg;

    localparam int MULT_N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mult_state_t;

endpackage
`default_nettype wire

// File: rtl/acc_aq_shr.sv
`default_nettype none
// ============================================================================
//  Module      : acc_aq_shr
//  Description : (N+1)-bit accumulator A and N-bit Q register pair with load,
//                joint right shift and A write. Priority: load > shift > write.
//  Revision    : 1.0
// ============================================================================
module acc_aq_shr
    import arith_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         wr_a_i,
    input  logic [N-1:0] d_i,
    input  logic [N:0]   a_i,
    output logic [N:0]   a_o,
    output logic [N-1:0] q_o
);

    logic [N:0]   a_q;
    logic [N:0]   a_d;
    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    always_comb begin
        a_d = a_q;
        q_d = q_q;
        if (load_i) begin
            a_d = '0;
            q_d = d_i;
        end else if (shift_i) begin
            // Logical shift of the concatenated {A,Q}; A[0] drops into Q[N-1].
            {a_d, q_d} = {1'b0, a_q, q_q[N-1:1]};
        end else if (wr_a_i) begin
            a_d = a_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            q_q <= '0;
        end else begin
            a_q <= a_d;
            q_q <= q_d;
        end
    end

    assign a_o = a_q;
    assign q_o = q_q;

endmodule
`default_nettype wire

// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq
//  Description : Sequential unsigned shift-and-add multiplier, N iterations of
//                ADD/SHIFT producing a 2N-bit product with a done strobe.
//  Revision    : 1.0
// ============================================================================
module mult_seq
    import arith_pkg::*;
#(
    parameter int N = MULT_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           done
);

    localparam int CNT_W = $clog2(N + 1);

    mult_state_t  state_q;
    mult_state_t  state_d;
    logic [N-1:0] m_q;
    logic [N-1:0] m_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic         load;
    logic         shift;
    logic         wr_a;
    logic [N:0]   a;
    logic [N-1:0] q;
    logic [N:0]   sum;

    // Sum is N+1 bits wide so the carry lands in A[N].
    assign sum = a + {1'b0, m_q};

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        shift   = 1'b0;
        wr_a    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    m_d     = multiplicand;
                    cnt_d   = CNT_W'(N);
                    state_d = ADD;
                end
            end
            ADD: begin
                wr_a    = q[0];
                state_d = SHIFT;
            end
            SHIFT: begin
                shift   = 1'b1;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? DONE : ADD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    acc_aq_shr #(
        .N (N)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .shift_i (shift),
        .wr_a_i  (wr_a),
        .d_i     (multiplier),
        .a_i     (sum),
        .a_o     (a),
        .q_o     (q)
    );

    assign product = {a[N-1:0], q};
    assign busy    = (state_q == ADD) || (state_q == SHIFT);
    assign done    = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq
//  Description : Self-checking bench for mult_seq at N=4 and N=8 against a*b.
//  Revision    : 1.0
// ============================================================================
module tb_mult_seq;
    import arith_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start4 = 1'b0;
    logic [3:0]  mc4 = '0;
    logic [3:0]  mp4 = '0;
    logic [7:0]  prod4;
    logic        busy4;
    logic        done4;

    logic        start8 = 1'b0;
    logic [7:0]  mc8 = '0;
    logic [7:0]  mp8 = '0;
    logic [15:0] prod8;
    logic        busy8;
    logic        done8;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq #(.N(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .multiplicand (mc4),
        .multiplier   (mp4),
        .product      (prod4),
        .busy         (busy4),
        .done         (done4)
    );

    mult_seq #(.N(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
        .multiplicand (mc8),
        .multiplier   (mp8),
        .product      (prod8),
        .busy         (busy8),
        .done         (done8)
    );

    always #5 clk = ~clk;

    // One start pulse, then count edges from the accepting edge until done.
    task automatic run_op(input bit wide, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat,
                          output int busy_cyc, output bit one_wide);
        @(negedge clk);
        if (wide) begin start8 = 1'b1; mc8 = a; mp8 = b; end
        else begin start4 = 1'b1; mc4 = a[3:0]; mp4 = b[3:0]; end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        lat = -1;
        busy_cyc = 0;
        prod = '0;
        one_wide = 1'b0;
        for (int e = 0; e <= 40; e++) begin
            if (wide ? done8 : done4) begin
                lat  = e;
                prod = wide ? prod8 : {8'h00, prod4};
                break;
            end
            if (wide ? busy8 : busy4) busy_cyc++;
            @(posedge clk);
            #1;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
            one_wide = !(wide ? done8 : done4);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({prod4, busy4, done4} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_n4: got prod=%h busy=%b done=%b, want 0/0/0", prod4, busy4, done4);
        end
        n_checks++;
        if ({prod8, busy8, done8} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_n8: got prod=%h busy=%b done=%b, want 0/0/0", prod8, busy8, done8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int lat, bc;
        bit ow;
        run_op(1'b0, 8'd13, 8'd11, p, lat, bc, ow);
        n_checks++;
        if (p !== 16'd143) begin
            n_fail++;
            $display("FAIL basic_product: got %0d, want 143", p);
        end
        n_checks++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d, want 8", lat);
        end
        n_checks++;
        if (bc !== 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        n_checks++;
        if (ow !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_width: got one_wide=%b, want 1", ow);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (prod4 !== 8'h8F) begin
            n_fail++;
            $display("FAIL basic_hold_idle: got %h, want 8f", prod4);
        end
    endtask

    task automatic test_corners();
        logic [15:0] p;
        int lat, bc;
        bit ow;
        logic [7:0] ta [3] = '{8'd15, 8'd0, 8'd7};
        logic [7:0] tb [3] = '{8'd15, 8'd9, 8'd0};
        for (int i = 0; i < 3; i++) begin
            run_op(1'b0, ta[i], tb[i], p, lat, bc, ow);
            n_checks++;
            if (p !== 16'(ta[i] * tb[i])) begin
                n_fail++;
                $display("FAIL corner_%0dx%0d: got %0d, want %0d", ta[i], tb[i], p, ta[i] * tb[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dcount = 0;
        int first_e = -1;
        logic [7:0] p = '0;
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd13; mp4 = 4'd11;
        @(posedge clk);
        #1;
        // start stays high through ADD, SHIFT and DONE sampling edges
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk);
            #1;
            if (e == 9) start4 = 1'b0;
            if (done4) begin
                dcount++;
                if (first_e < 0) begin first_e = e; p = prod4; end
            end
        end
        n_checks++;
        if (dcount !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d, want 1", dcount);
        end
        n_checks++;
        if (first_e !== 8 || p !== 8'd143) begin
            n_fail++;
            $display("FAIL ignore_result: got edge=%0d prod=%0d, want edge=8 prod=143", first_e, p);
        end
        n_checks++;
        if (prod4 !== 8'd143 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_hold: got prod=%0d busy=%b, want 143/0", prod4, busy4);
        end
    endtask

    task automatic test_back_to_back();
        int de [$];
        logic [7:0] dp [$];
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd3; mp4 = 4'd5;
        @(posedge clk);
        #1;
        mc4 = 4'd6; mp4 = 4'd7;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (e == 10) start4 = 1'b0;
            if (done4) begin de.push_back(e); dp.push_back(prod4); end
        end
        n_checks++;
        if (de.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d done strobes, want 2", de.size());
        end else begin
            n_checks++;
            if (de[0] !== 8 || de[1] !== 18) begin
                n_fail++;
                $display("FAIL b2b_spacing: got edges %0d,%0d, want 8,18", de[0], de[1]);
            end
            n_checks++;
            if (dp[0] !== 8'd15 || dp[1] !== 8'd42) begin
                n_fail++;
                $display("FAIL b2b_products: got %0d,%0d, want 15,42", dp[0], dp[1]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] p;
        int lat, bc;
        bit ow;
        @(negedge clk);
        start4 = 1'b1; mc4 = 4'd13; mp4 = 4'd11;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({prod4, busy4, done4} !== 10'd0 || dut4.state_q !== IDLE) begin
            n_fail++;
            $display("FAIL async_reset: got prod=%h busy=%b done=%b state=%0d, want 0/0/0/IDLE",
                     prod4, busy4, done4, dut4.state_q);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(1'b0, 8'd9, 8'd9, p, lat, bc, ow);
        n_checks++;
        if (p !== 16'd81 || lat !== 8) begin
            n_fail++;
            $display("FAIL post_reset_9x9: got prod=%0d lat=%0d, want 81/8", p, lat);
        end
    endtask

    task automatic test_sweep_n4();
        logic [15:0] p;
        int lat, bc;
        bit ow;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op(1'b0, 8'(a), 8'(b), p, lat, bc, ow);
                n_checks++;
                if (p !== 16'(a * b)) begin
                    n_fail++;
                    $display("FAIL sweep_n4 %0dx%0d: got %0d, want %0d", a, b, p, a * b);
                end
                n_checks++;
                if (lat !== 8 || ow !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sweep_n4_timing %0dx%0d: got lat=%0d one_wide=%b, want 8/1", a, b, lat, ow);
                end
            end
        end
    endtask

    task automatic test_random_n8();
        logic [15:0] p;
        int lat, bc;
        bit ow;
        logic [7:0] a, b;
        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (i == 0) begin a = 8'hFF; b = 8'hFF; end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_op(1'b1, a, b, p, lat, bc, ow);
            n_checks++;
            if (p !== 16'(a) * 16'(b)) begin
                n_fail++;
                $display("FAIL rand_n8 %0dx%0d: got %0d, want %0d", a, b, p, 16'(a) * 16'(b));
            end
            n_checks++;
            if (lat !== 16 || bc !== 16 || ow !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_n8_timing %0dx%0d: got lat=%0d busy=%0d one_wide=%b, want 16/16/1",
                         a, b, lat, bc, ow);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        test_sweep_n4();
        test_random_n8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
